// File: rtl/key_event_pkg.sv
// Purpose: shared types and widths for the key gesture classifier.
//   key_evt_state_t : gesture FSM state encoding
//   MS_W            : width of the millisecond gesture timer
package key_event_pkg;

    localparam int unsigned MS_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } key_evt_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Purpose: free-running divider producing a one-cycle tick every F_CLK/1000 clocks (1 ms).
// Ports:
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   tick out registered one-cycle pulse, once per millisecond
module ms_tick_gen #(
    parameter int unsigned F_CLK = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = (F_CLK / 1000 > 0) ? F_CLK / 1000 : 1;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Wrap at DIV-1; tick is registered so it lands one cycle after the wrap value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_W'(DIV - 1));
            if (cnt == CNT_W'(DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_event_fsm.sv
// Purpose: classify a debounced, active-low key level into one-cycle gesture pulses
//          (press, release, short click, double click, long press, auto-repeat).
// Optional feature: define KEY_AUTOREPEAT_EN to enable repeat_pulse while the key is held long.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   key_state     in   debounced key level, 0 = pressed, asynchronous to clk
//   key_level     out  synchronised pressed level, 1 = pressed
//   press_pulse   out  one cycle on every press edge
//   release_pulse out  one cycle on every release edge
//   short_click   out  single press/release with no second press within DOUBLE_MS
//   double_click  out  on release of a second press
//   long_press    out  when a hold reaches LONG_MS
//   repeat_pulse  out  every REPEAT_MS while held long (constant 0 without KEY_AUTOREPEAT_EN)
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int unsigned F_CLK     = 50000000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DOUBLE_MS = 300,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic key_state,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    // Elaboration-time sanity check of the timing parameters.
    if (F_CLK < 1000 || LONG_MS < 1 || LONG_MS > 65535 || DOUBLE_MS < 1 || DOUBLE_MS > 65535 ||
        REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_param_check
        $error("key_event_fsm: timing parameter out of range");
    end

    logic            s1;
    logic            s2;
    logic            prev;
    logic            tick;
    logic            press_edge;
    logic            release_edge;
    logic            long_to;
    logic            double_to;
    logic [MS_W-1:0] ms_cnt;
    logic [MS_W-1:0] ms_inc;
    key_evt_state_t  state;

    ms_tick_gen #(
        .F_CLK (F_CLK)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Edges on the synchronised active-low level.
    assign press_edge   = prev & ~s2;
    assign release_edge = ~prev & s2;

    // Saturating millisecond count and timeout decodes (timeout X == tick at count X-1).
    assign ms_inc    = (tick && (ms_cnt != {MS_W{1'b1}})) ? ms_cnt + MS_W'(1) : ms_cnt;
    assign long_to   = tick && (ms_cnt == MS_W'(LONG_MS - 1));
    assign double_to = tick && (ms_cnt == MS_W'(DOUBLE_MS - 1));

`ifdef KEY_AUTOREPEAT_EN
    logic rpt_to;
    assign rpt_to = tick && (ms_cnt == MS_W'(REPEAT_MS - 1));
`else
    assign repeat_pulse = 1'b0;
`endif

    // Synchroniser, edge pulses, gesture FSM and millisecond timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= 1'b1;
            s2            <= 1'b1;
            prev          <= 1'b1;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            ms_cnt        <= '0;
            state         <= IDLE;
        end else begin
            s1            <= key_state;
            s2            <= s1;
            prev          <= s2;
            key_level     <= ~s2;
            press_pulse   <= press_edge;
            release_pulse <= release_edge;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            ms_cnt        <= ms_inc;

            // Edges are tested before timeouts so a coincident edge wins.
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        state  <= PRESS1;
                        ms_cnt <= '0;
                    end
                end
                PRESS1: begin
                    if (release_edge) begin
                        state  <= WAIT2;
                        ms_cnt <= '0;
                    end else if (long_to) begin
                        state      <= LONG;
                        ms_cnt     <= '0;
                        long_press <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (press_edge) begin
                        state  <= PRESS2;
                        ms_cnt <= '0;
                    end else if (double_to) begin
                        state       <= IDLE;
                        ms_cnt      <= '0;
                        short_click <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (release_edge) begin
                        state        <= IDLE;
                        ms_cnt       <= '0;
                        double_click <= 1'b1;
                    end else if (long_to) begin
                        state      <= LONG;
                        ms_cnt     <= '0;
                        long_press <= 1'b1;
                    end
                end
                LONG: begin
                    if (release_edge) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rpt_to) begin
                        // Period restarts after every repeat.
                        ms_cnt       <= '0;
                        repeat_pulse <= 1'b1;
                    end
`endif
                end
                default: begin
                    state  <= IDLE;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_fsm.sv
// Purpose: scoreboard bench for key_event_fsm. Stimulus pushes hand-computed (pulse, cycle)
// expectations; a negedge monitor pops one entry per observed pulse and compares.
// With F_CLK=10000 and reset released before edge 6, the FSM sees tick at edges 16,26,36,...
// until the mid-run reset at edge 1261, after which it sees tick at edges 1272,1282,...
module tb_key_event_fsm;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic key_state;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    key_event_fsm #(
        .F_CLK     (10000),
        .LONG_MS   (20),
        .DOUBLE_MS (8),
        .REPEAT_MS (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_state     (key_state),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_click   (short_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "press_pulse";
            1: return "release_pulse";
            2: return "short_click";
            3: return "double_click";
            4: return "long_press";
            default: return "repeat_pulse";
        endcase
    endfunction

    // Advance to 1 ns after posedge number n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %b required %b (cyc %0d)", name, got, req, cyc);
        end
    endtask

    function automatic logic [6:0] outs();
        return {repeat_pulse, long_press, double_click, short_click, release_pulse, press_pulse,
                key_level};
    endfunction

    // Monitor: every pulse observed must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [5:0] p;
        exp_t       e;
        p = {repeat_pulse, long_press, double_click, short_click, release_pulse, press_pulse};
        for (int k = 0; k < 6; k++) begin
            if (p[k] === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected %s: seen at cyc %0d, required none", kname(k), cyc);
                end else begin
                    e = q.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        bad++;
                        $display("FAIL event: got %s at cyc %0d, required %s at cyc %0d",
                                 kname(k), cyc, kname(e.kind), e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        key_state = 1'b1;
        goto(3);
        chk("reset_outputs", outs(), 7'b0);
        goto(5);
        rst = 1'b0;

        // 1: single click, short_click after DOUBLE_MS of quiet.
        goto(40);
        key_state = 1'b0;
        expect_evt(0, 43);
        goto(42);
        chk("key_level_before", outs(), 7'b0);
        goto(43);
        chk("key_level_press", {6'b0, key_level}, 7'b1);
        goto(90);
        key_state = 1'b1;
        expect_evt(1, 93);
        expect_evt(2, 166);
        goto(100);
        chk("key_level_released", {6'b0, key_level}, 7'b0);

        // 2: double click, double_click coincident with second release.
        goto(200);
        key_state = 1'b0;
        expect_evt(0, 203);
        goto(230);
        key_state = 1'b1;
        expect_evt(1, 233);
        goto(260);
        key_state = 1'b0;
        expect_evt(0, 263);
        goto(290);
        key_state = 1'b1;
        expect_evt(1, 293);
        expect_evt(3, 293);

        // 3: long hold.
        goto(400);
        key_state = 1'b0;
        expect_evt(0, 403);
        expect_evt(4, 596);
`ifdef KEY_AUTOREPEAT_EN
        expect_evt(5, 646);
        expect_evt(5, 696);
`endif
        goto(700);
        key_state = 1'b1;
        expect_evt(1, 703);

        // 4: release edge lands on the LONG_MS timeout edge (996): edge wins.
        goto(800);
        key_state = 1'b0;
        expect_evt(0, 803);
        goto(993);
        key_state = 1'b1;
        expect_evt(1, 996);
        expect_evt(2, 1076);

        // 5: reset while in PRESS2 with the key held.
        goto(1200);
        key_state = 1'b0;
        expect_evt(0, 1203);
        goto(1220);
        key_state = 1'b1;
        expect_evt(1, 1223);
        goto(1240);
        key_state = 1'b0;
        expect_evt(0, 1243);
        goto(1260);
        rst = 1'b1;
        goto(1261);
        rst = 1'b0;
        chk("mid_reset_outputs", outs(), 7'b0);
        expect_evt(0, 1264);
        goto(1280);
        key_state = 1'b1;
        expect_evt(1, 1283);
        expect_evt(2, 1362);

        // 6: second press 9 ms after release: short_click, then a fresh PRESS1 to long.
        goto(1500);
        key_state = 1'b0;
        expect_evt(0, 1503);
        goto(1530);
        key_state = 1'b1;
        expect_evt(1, 1533);
        expect_evt(2, 1612);
        goto(1620);
        key_state = 1'b0;
        expect_evt(0, 1623);
        expect_evt(4, 1822);
        goto(1830);
        key_state = 1'b1;
        expect_evt(1, 1833);

        goto(1950);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending: %0d expected pulses never seen, required 0 (first %s at cyc %0d)",
                     q.size(), kname(q[0].kind), q[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
